// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: stage enables/flushes, PC control and the data-memory
// request handshake. Handles load-use stalls, taken-branch flushes (branch
// resolved in MEM) and multi-cycle memory waits with a timeout abort.
module pipeline_ctrl #(
   parameter int unsigned REG_W       = 5,
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [REG_W-1:0] if_id_rs,
   input  logic [REG_W-1:0] if_id_rt,
   input  logic             id_ex_memRead,
   input  logic [REG_W-1:0] id_ex_rt,
   input  logic             ex_mem_branch,
   input  logic             ex_mem_zero,
   input  logic             ex_mem_memRead,
   input  logic             ex_mem_memWrite,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             pc_write,
   output logic             pc_src,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_en,
   output logic             idex_flush,
   output logic             exmem_en,
   output logic             exmem_flush,
   output logic             memwb_en,
   output logic             mem_error,
   output logic [CNT_W-1:0] stall_count
);

   localparam int unsigned WaitW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

   typedef enum logic [0:0] {StRun, StMemWait} state_t;

   state_t           stateQ, stateD;
   logic [WaitW-1:0] waitCntQ, waitCntD;
   logic             memErrorQ, memErrorD;
   logic [CNT_W-1:0] stallCountQ;

   logic memOp;
   logic taken;
   logic hazard;
   logic freeze;
   logic stalled;

   assign memOp  = ex_mem_memRead | ex_mem_memWrite;
   assign taken  = ex_mem_branch & ex_mem_zero;
   assign hazard = id_ex_memRead && (id_ex_rt != '0) &&
                   ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));
   // A taken branch squashes the dependent instruction, so no bubble is counted then.
   assign stalled = freeze | (hazard & ~taken);

   // State register, wait counter, sticky error and stall counter.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stateQ      <= StRun;
         waitCntQ    <= '0;
         memErrorQ   <= 1'b0;
         stallCountQ <= '0;
      end else begin
         stateQ    <= stateD;
         waitCntQ  <= waitCntD;
         memErrorQ <= memErrorD;
         if (stalled && (stallCountQ != '1)) begin
            stallCountQ <= stallCountQ + CNT_W'(1);
         end
      end
   end

   // Next-state logic and freeze decision for the memory handshake.
   always_comb begin
      stateD    = stateQ;
      waitCntD  = waitCntQ;
      memErrorD = memErrorQ;
      freeze    = 1'b0;
      unique case (stateQ)
         StRun: begin
            if (memOp && !mem_ready) begin
               freeze   = 1'b1;
               stateD   = StMemWait;
               waitCntD = WaitW'(1);
            end
         end
         StMemWait: begin
            if (mem_ready) begin
               stateD   = StRun;
               waitCntD = '0;
            end else if (waitCntQ == WaitLast) begin
               // Abort: drop the access and let the pipeline move on.
               memErrorD = 1'b1;
               stateD    = StRun;
               waitCntD  = '0;
            end else begin
               freeze   = 1'b1;
               waitCntD = waitCntQ + WaitW'(1);
            end
         end
         default: begin
            stateD   = StRun;
            waitCntD = '0;
         end
      endcase
   end

   // Control outputs: freeze beats branch flush beats load-use stall.
   always_comb begin
      mem_req     = 1'b0;
      pc_write    = 1'b0;
      pc_src      = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b0;
      idex_en     = 1'b0;
      idex_flush  = 1'b0;
      exmem_en    = 1'b0;
      exmem_flush = 1'b0;
      memwb_en    = 1'b0;
      if (!reset_n) begin
         // Bubbles everywhere while reset is held.
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
      end else begin
         mem_req = memOp | (stateQ == StMemWait);
         if (!freeze) begin
            pc_write = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
            if (taken) begin
               pc_src      = 1'b1;
               ifid_flush  = 1'b1;
               idex_flush  = 1'b1;
               exmem_flush = 1'b1;
            end else if (hazard) begin
               pc_write   = 1'b0;
               ifid_en    = 1'b0;
               idex_flush = 1'b1;
            end
         end
      end
   end

   assign mem_error   = memErrorQ;
   assign stall_count = stallCountQ;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: table of single-cycle vectors in RUN plus
// hand-written sequences for reset, memory wait, timeout and saturation.
module tb_pipeline_ctrl;

   localparam int unsigned REG_W = 5;

   // Output vector order:
   // {mem_req, pc_write, pc_src, ifid_en, ifid_flush, idex_en, idex_flush,
   //  exmem_en, exmem_flush, memwb_en}
   localparam logic [9:0] ORst    = 10'b0000101010;
   localparam logic [9:0] ONorm   = 10'b0101010101;
   localparam logic [9:0] ONormMq = 10'b1101010101;
   localparam logic [9:0] OLu     = 10'b0000011101;
   localparam logic [9:0] OLuMq   = 10'b1000011101;
   localparam logic [9:0] OBr     = 10'b0111111111;
   localparam logic [9:0] OBrMq   = 10'b1111111111;
   localparam logic [9:0] OFrz    = 10'b1000000000;

   logic             clock = 1'b0;
   logic             reset_n = 1'b0;
   logic [REG_W-1:0] if_id_rs, if_id_rt, id_ex_rt;
   logic             id_ex_memRead, ex_mem_branch, ex_mem_zero;
   logic             ex_mem_memRead, ex_mem_memWrite, mem_ready;
   logic             mem_req, pc_write, pc_src, ifid_en, ifid_flush, idex_en, idex_flush;
   logic             exmem_en, exmem_flush, memwb_en, mem_error;
   logic [15:0]      stall_count;
   logic [9:0]       outVec;

   // Narrow-counter instance sharing the same stimulus, used for saturation.
   logic             s_mem_req, s_pc_write, s_pc_src, s_ifid_en, s_ifid_flush, s_idex_en;
   logic             s_idex_flush, s_exmem_en, s_exmem_flush, s_memwb_en, s_mem_error;
   logic [3:0]       s_stall_count;

   int checks = 0;
   int errors = 0;
   int expCount;

   always #5 clock = ~clock;

   assign outVec = {mem_req, pc_write, pc_src, ifid_en, ifid_flush, idex_en, idex_flush,
                    exmem_en, exmem_flush, memwb_en};

   pipeline_ctrl #(.REG_W(REG_W), .MEM_TIMEOUT(16), .CNT_W(16)) dut (
      .clock(clock), .reset_n(reset_n),
      .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
      .id_ex_memRead(id_ex_memRead), .id_ex_rt(id_ex_rt),
      .ex_mem_branch(ex_mem_branch), .ex_mem_zero(ex_mem_zero),
      .ex_mem_memRead(ex_mem_memRead), .ex_mem_memWrite(ex_mem_memWrite),
      .mem_ready(mem_ready), .mem_req(mem_req), .pc_write(pc_write), .pc_src(pc_src),
      .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en), .idex_flush(idex_flush),
      .exmem_en(exmem_en), .exmem_flush(exmem_flush), .memwb_en(memwb_en),
      .mem_error(mem_error), .stall_count(stall_count)
   );

   pipeline_ctrl #(.REG_W(REG_W), .MEM_TIMEOUT(16), .CNT_W(4)) dutSat (
      .clock(clock), .reset_n(reset_n),
      .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
      .id_ex_memRead(id_ex_memRead), .id_ex_rt(id_ex_rt),
      .ex_mem_branch(ex_mem_branch), .ex_mem_zero(ex_mem_zero),
      .ex_mem_memRead(ex_mem_memRead), .ex_mem_memWrite(ex_mem_memWrite),
      .mem_ready(mem_ready), .mem_req(s_mem_req), .pc_write(s_pc_write), .pc_src(s_pc_src),
      .ifid_en(s_ifid_en), .ifid_flush(s_ifid_flush), .idex_en(s_idex_en),
      .idex_flush(s_idex_flush), .exmem_en(s_exmem_en), .exmem_flush(s_exmem_flush),
      .memwb_en(s_memwb_en), .mem_error(s_mem_error), .stall_count(s_stall_count)
   );

   typedef struct {
      logic             idRead;
      logic [REG_W-1:0] idRt;
      logic [REG_W-1:0] ifRs;
      logic [REG_W-1:0] ifRt;
      logic             br;
      logic             zr;
      logic             exRd;
      logic             exWr;
      logic             rdy;
      logic [9:0]       expOut;
      logic             expStall;
   } vec_t;

   localparam int NV = 12;
   vec_t vec [NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idleInputs();
      if_id_rs = '0; if_id_rt = '0; id_ex_rt = '0; id_ex_memRead = 1'b0;
      ex_mem_branch = 1'b0; ex_mem_zero = 1'b0;
      ex_mem_memRead = 1'b0; ex_mem_memWrite = 1'b0; mem_ready = 1'b0;
   endtask

   task automatic applyVec(input vec_t v);
      id_ex_memRead = v.idRead; id_ex_rt = v.idRt; if_id_rs = v.ifRs; if_id_rt = v.ifRt;
      ex_mem_branch = v.br; ex_mem_zero = v.zr;
      ex_mem_memRead = v.exRd; ex_mem_memWrite = v.exWr; mem_ready = v.rdy;
   endtask

   task automatic doReset();
      @(negedge clock);
      idleInputs();
      reset_n = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   initial begin
      //          idRd rt   rs   rtIf br  zr  exRd exWr rdy  expOut  stall
      vec[0]  = '{1'b0, 5'd0, 5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ONorm,   1'b0};
      vec[1]  = '{1'b1, 5'd8, 5'd8, 5'd3,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, OLu,     1'b1};
      vec[2]  = '{1'b1, 5'd5, 5'd1, 5'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, OLu,     1'b1};
      vec[3]  = '{1'b1, 5'd0, 5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ONorm,   1'b0};
      vec[4]  = '{1'b0, 5'd8, 5'd8, 5'd8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ONorm,   1'b0};
      vec[5]  = '{1'b1, 5'd8, 5'd9, 5'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ONorm,   1'b0};
      vec[6]  = '{1'b1, 5'd8, 5'd8, 5'd3,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, OBr,     1'b0};
      vec[7]  = '{1'b0, 5'd0, 5'd0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ONorm,   1'b0};
      vec[8]  = '{1'b0, 5'd0, 5'd0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ONorm,   1'b0};
      vec[9]  = '{1'b0, 5'd0, 5'd0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, ONormMq, 1'b0};
      vec[10] = '{1'b1, 5'd31, 5'd2, 5'd31, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, OLuMq,  1'b1};
      vec[11] = '{1'b0, 5'd0, 5'd0, 5'd0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, OBrMq,   1'b0};

      // Reset held: outputs forced regardless of a pending memory op.
      idleInputs();
      ex_mem_memRead = 1'b1;
      reset_n = 1'b0;
      #2;
      check("rst_outs", 32'(outVec), 32'(ORst));
      check("rst_err", 32'(mem_error), 32'd0);
      check("rst_cnt", 32'(stall_count), 32'd0);
      @(negedge clock);
      check("rst_outs_held", 32'(outVec), 32'(ORst));
      ex_mem_memRead = 1'b0;
      reset_n = 1'b1;
      #2;
      check("rst_release", 32'(outVec), 32'(ONorm));

      // Single-cycle vectors in RUN.
      expCount = 0;
      for (int i = 0; i < NV; i++) begin
         @(negedge clock);
         applyVec(vec[i]);
         #2;
         check($sformatf("vec%0d_out", i), 32'(outVec), 32'(vec[i].expOut));
         if (vec[i].expStall) expCount++;
         @(posedge clock);
         #1;
         check($sformatf("vec%0d_cnt", i), 32'(stall_count), 32'(expCount));
      end

      // Memory wait: 3 frozen cycles, branch arriving while frozen acts on release.
      doReset();
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         ex_mem_memRead = 1'b1;
         mem_ready = 1'b0;
         if (k > 0) begin
            ex_mem_branch = 1'b1;
            ex_mem_zero = 1'b1;
         end
         #2;
         check($sformatf("wait_frz%0d", k), 32'(outVec), 32'(OFrz));
      end
      @(negedge clock);
      mem_ready = 1'b1;
      #2;
      check("wait_release", 32'(outVec), 32'(OBrMq));
      @(posedge clock);
      #1;
      check("wait_cnt", 32'(stall_count), 32'd3);
      @(negedge clock);
      idleInputs();
      #2;
      check("wait_back_run", 32'(outVec), 32'(ONorm));

      // Timeout: 15 frozen cycles, release on the 16th, sticky error.
      doReset();
      for (int k = 1; k <= 15; k++) begin
         @(negedge clock);
         ex_mem_memRead = 1'b1;
         mem_ready = 1'b0;
         #2;
         check($sformatf("to_frz%0d", k), 32'(outVec), 32'(OFrz));
      end
      @(negedge clock);
      #2;
      check("to_release", 32'(outVec), 32'(ONormMq));
      check("to_err_before", 32'(mem_error), 32'd0);
      @(posedge clock);
      #1;
      check("to_err_set", 32'(mem_error), 32'd1);
      check("to_cnt", 32'(stall_count), 32'd15);
      check("sat_cnt15", 32'(s_stall_count), 32'd15);
      @(negedge clock);
      idleInputs();
      id_ex_memRead = 1'b1;
      id_ex_rt = 5'd8;
      if_id_rs = 5'd8;
      #2;
      check("to_after_lu", 32'(outVec), 32'(OLu));
      @(posedge clock);
      #1;
      check("to_cnt16", 32'(stall_count), 32'd16);
      check("sat_hold", 32'(s_stall_count), 32'd15);
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         idleInputs();
         #2;
         check($sformatf("to_err_sticky%0d", k), 32'(mem_error), 32'd1);
         check($sformatf("to_run%0d", k), 32'(outVec), 32'(ONorm));
      end

      // Reset asserted in MEM_WAIT drops mem_req at once and clears state.
      doReset();
      @(negedge clock);
      ex_mem_memRead = 1'b1;
      mem_ready = 1'b0;
      @(negedge clock);
      #2;
      check("mid_req_on", 32'(mem_req), 32'd1);
      reset_n = 1'b0;
      #1;
      check("mid_req_off", 32'(mem_req), 32'd0);
      check("mid_outs", 32'(outVec), 32'(ORst));
      check("mid_cnt", 32'(stall_count), 32'd0);
      @(negedge clock);
      idleInputs();
      reset_n = 1'b1;
      #2;
      check("mid_run", 32'(outVec), 32'(ONorm));
      check("mid_err", 32'(mem_error), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
